// File: rtl/uart_tx_seq.sv
// uart_tx_seq: FIFO-buffered register-bus sequencer driving the uart_core TX path.
// Optional WAIT_DONE timeout with sticky err_o when UART_TX_SEQ_TIMEOUT_EN is defined.
module uart_tx_seq #(
  parameter int DEPTH       = 8,
  parameter int BAUD_DIV    = 87,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_valid_i,
  input  logic [7:0]               s_data_i,
  output logic                     s_ready_o,
  input  logic                     baud_we_i,
  input  logic [15:0]              baud_i,
  output logic                     uart_we_o,
  output logic                     uart_ren_o,
  output logic [7:0]               uart_addr_o,
  output logic [31:0]              uart_wdata_o,
  input  logic                     uart_intr_tx_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     done_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {CFG_BAUD, IDLE, LOAD, START, WAIT_DONE, CLR, GAP} state_t;
  state_t         r_state, w_next;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [AW:0]    r_cnt;
  logic [15:0]    r_baud;
  logic           r_pend;
  logic [7:0]     r_addr, w_addr;
  logic [31:0]    r_wdata, w_wdata;
  logic           w_we, w_done, w_push, w_pop, w_full, w_empty, w_breq, w_to, w_tof;
  assign w_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_push  = s_valid_i & ~w_full;
  assign w_pop   = r_state == LOAD;
  assign w_breq  = baud_we_i & (baud_i != 16'd0);
`ifdef UART_TX_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_tcnt;
  logic          r_err, r_tof;
  assign w_to  = r_state == WAIT_DONE && !uart_intr_tx_i && r_tcnt == CW'(TIMEOUT_CYC - 1);
  assign w_tof = r_tof;
  assign err_o = r_err & ~rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
      r_tof  <= 1'b0;
    end else begin
      r_tcnt <= r_state == WAIT_DONE ? r_tcnt + 1'b1 : '0;
      r_err  <= w_to | (r_err & ~err_clr_i);
      r_tof  <= w_to;
    end
  end
`else
  logic w_unused;
  assign w_unused = err_clr_i | (TIMEOUT_CYC == 0);
  assign w_to  = 1'b0;
  assign w_tof = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_done  = 1'b0;
    case (r_state)
      CFG_BAUD: begin
        w_we    = 1'b1;
        w_addr  = 8'h00;
        w_wdata = {16'h0, r_baud};
        w_next  = IDLE;
      end
      IDLE: w_next = r_pend ? CFG_BAUD : !w_empty ? LOAD : IDLE;
      LOAD: begin
        w_we    = 1'b1;
        w_addr  = 8'h04;
        w_wdata = {24'h0, r_mem[r_rp]};
        w_next  = START;
      end
      START: begin
        w_we    = 1'b1;
        w_addr  = 8'h10;
        w_wdata = 32'd1;
        w_next  = WAIT_DONE;
      end
      WAIT_DONE: w_next = (uart_intr_tx_i | w_to) ? CLR : WAIT_DONE;
      CLR: begin
        w_we    = 1'b1;
        w_addr  = 8'h10;
        w_wdata = 32'd0;
        w_done  = ~w_tof;
        w_next  = GAP;
      end
      GAP: w_next = uart_intr_tx_i ? GAP : IDLE;
      default: w_next = CFG_BAUD;
    endcase
  end
  // bus outputs are combinational from state but forced quiet while reset is held
  assign uart_we_o    = w_we & ~rst_i;
  assign uart_addr_o  = rst_i ? 8'h00 : w_addr;
  assign uart_wdata_o = rst_i ? 32'h0 : w_wdata;
  assign uart_ren_o   = 1'b0;
  assign s_ready_o    = ~w_full & ~rst_i;
  assign level_o      = rst_i ? '0 : r_cnt;
  assign done_o       = w_done & ~rst_i;
  assign busy_o       = r_state != IDLE || !w_empty;
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= s_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= CFG_BAUD;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_baud  <= 16'(BAUD_DIV);
      r_pend  <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_baud  <= w_breq ? baud_i : r_baud;
      r_pend  <= w_breq | (r_pend & (r_state != CFG_BAUD));
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end
endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: directed and randomized checks of uart_tx_seq against a queue-based byte/bus model.
module tb_uart_tx_seq;
  logic        clk = 0, rst = 1, s_valid = 0, baud_we = 0, intr = 0, err_clr = 0;
  logic [7:0]  s_data = 0;
  logic [15:0] baud = 0;
  logic        s_ready, uart_we, uart_ren, busy, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  level;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [39:0] wlog[$];
  int          mlevel = 0, gs = 3, pops = 0, dones = 0, dly = 0, hold = 0, t;
  logic [15:0] mshadow = 16'd87;
  bit          mpend = 0, popq = 0, auto_en = 0;

  uart_tx_seq dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .baud_we_i(baud_we), .baud_i(baud), .uart_we_o(uart_we), .uart_ren_o(uart_ren),
    .uart_addr_o(addr), .uart_wdata_o(wdata), .uart_intr_tx_i(intr), .busy_o(busy),
    .level_o(level), .done_o(done), .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one cycle: apply the events of the edge just passed to the model, then check outputs
  task automatic step();
    bit push, pop, ok;
    @(negedge clk);
    if (rst) begin
      chk("rst_we", uart_we, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_done", done, 0);
      exp_q.delete();
      mlevel = 0; mshadow = 16'd87; mpend = 0; gs = 3; popq = 0;
      return;
    end
    push = s_valid && mlevel < 8;
    pop = popq;
    popq = 0;
    if (push) exp_q.push_back(s_data);
    mlevel = mlevel + int'(push) - int'(pop);
    if (baud_we && baud != 0) begin mshadow = baud; mpend = 1; end
    chk("level", level, mlevel);
    chk("ready", s_ready, mlevel < 8);
    if (uart_we) begin
      wlog.push_back({addr, wdata});
      ok = gs == 0 ? (addr == 8'h00 || addr == 8'h04) :
           gs == 1 ? (addr == 8'h10 && wdata == 1) :
           gs == 2 ? (addr == 8'h10 && wdata == 0) : addr == 8'h00;
      chk("seq", ok, 1);
      if (addr == 8'h00) begin
        chk("baud_val", wdata, {16'h0, mshadow});
        mpend = 0; gs = 0;
      end else if (addr == 8'h04) begin
        popq = 1; pops++; gs = 1;
        if (exp_q.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", wdata, {24'h0, exp_q.pop_front()});
      end else if (wdata == 1) begin
        gs = 2;
        if (auto_en) dly = $urandom_range(1, 12);
      end else begin
        gs = 0;
        if (auto_en) hold = $urandom_range(1, 4);
      end
    end
    if (done) begin
      dones++;
      chk("done_at_clr", uart_we && addr == 8'h10 && wdata == 0, 1);
    end
    if (auto_en) begin
      if (dly > 0) begin dly--; if (dly == 0) intr = 1; end
      if (hold > 0) begin hold--; if (hold == 0) intr = 0; end
    end
  endtask

  task automatic drain();
    t = 0;
    while ((busy || mlevel != 0 || mpend) && t < 3000) begin step(); t++; end
    chk("drain_timeout", t < 3000, 1);
  endtask

  initial begin
    step(); step();
    @(posedge clk); #1 rst = 0;
    step();
    chk("post_rst_we", uart_we, 1);
    chk("post_rst_addr", addr, 8'h00);
    chk("post_rst_wdata", wdata, 87);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_we", uart_we, 0);
    chk("hold_addr", addr, 8'h00);

    // single byte with fixed latencies
    dones = 0;
    s_valid = 1; s_data = 8'hA5; step();
    s_valid = 0;
    chk("n1_we", uart_we, 0);
    step();
    chk("load", {uart_we, addr, wdata}, {1'b1, 8'h04, 32'hA5});
    step();
    chk("start", {uart_we, addr, wdata}, {1'b1, 8'h10, 32'h1});
    t = wlog.size();
    repeat (870) step();
    chk("wait_quiet", wlog.size(), t);
    intr = 1; step();
    chk("clr", {uart_we, addr, wdata, done}, {1'b1, 8'h10, 32'h0, 1'b1});
    step();
    chk("gap_quiet", {uart_we, done}, 0);
    step(); intr = 0; step(); step();
    chk("a5_busy", busy, 0);
    chk("a5_dones", dones, 1);

    // overfill: 10 back-to-back offers with the first byte stalled
    pops = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin s_valid = 1; s_data = 8'h10 + 8'(i); step(); end
    s_valid = 0; step();
    chk("full_level", level, 8);
    chk("full_ready", s_ready, 0);
    auto_en = 1; dly = 3;
    drain();
    chk("fill_pops", pops, 9);
    chk("fill_dones", dones, 9);
    chk("fill_left", exp_q.size(), 0);
    auto_en = 0;

    // baud request during WAIT_DONE is served after GAP, before the next byte
    wlog.delete();
    s_valid = 1; s_data = 8'h3C; step();
    s_data = 8'hC3; step();
    s_valid = 0;
    t = 0;
    while (gs != 2 && t < 50) begin step(); t++; end
    chk("b_start_timeout", t < 50, 1);
    baud_we = 1; baud = 16'd434; step();
    baud_we = 0; step(); step();
    intr = 1; step();
    chk("b_clr", {uart_we, addr, wdata}, {1'b1, 8'h10, 32'h0});
    t = wlog.size();
    repeat (3) step();
    chk("b_gap_quiet", wlog.size(), t);
    intr = 0;
    repeat (10) step();
    chk("b_nwr", wlog.size(), 6);
    if (wlog.size() >= 6) begin
      chk("b_w3", wlog[3], {8'h00, 32'd434});
      chk("b_w4", wlog[4], {8'h04, 32'hC3});
    end

    // reset with a byte in flight and three queued
    for (int i = 0; i < 3; i++) begin s_valid = 1; s_data = 8'h70 + 8'(i); step(); end
    s_valid = 0; step();
    chk("r_level", level, 3);
    rst = 1; step(); step();
    @(posedge clk); #1 rst = 0;
    step();
    chk("r_first", {uart_we, addr, wdata}, {1'b1, 8'h00, 32'd87});
    step();
    chk("r_idle", busy, 0);

`ifdef UART_TX_SEQ_TIMEOUT_EN
    dones = 0;
    s_valid = 1; s_data = 8'h5A; step();
    s_valid = 0;
    t = 0;
    while (gs != 2 && t < 50) begin step(); t++; end
    t = 0;
    while (!err && t < 3000) begin step(); t++; end
    chk("to_cycles", t, 2049);
    chk("to_clr", {uart_we, addr, wdata, done}, {1'b1, 8'h10, 32'h0, 1'b0});
    step(); step();
    chk("err_sticky", err, 1);
    err_clr = 1; step();
    err_clr = 0; step();
    chk("err_clr", err, 0);
    chk("to_dones", dones, 0);
`else
    chk("err_tied", err, 0);
`endif

    // randomized traffic with auto-responding UART
    pops = 0; dones = 0; auto_en = 1;
    repeat (1500) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
      baud_we = $urandom_range(0, 49) == 0;
      baud = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 65535));
      step();
    end
    s_valid = 0; baud_we = 0;
    drain();
    chk("rnd_left", exp_q.size(), 0);
    chk("rnd_dones", dones, pops);
    chk("rnd_pend", mpend, 0);
    chk("ren_tied", uart_ren, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_seq.md
Name: uart_tx_seq

Overview:
- Register-bus master that sequences the UART core's transmit path.
- Buffers bytes from a producer in a small FIFO and programs the baud divisor.
- For each byte, writes TX data, arms TX_EN, waits for intr_tx, then disarms TX_EN.
- Sits between the SoC byte producer (CPU shim or DMA) and the uart_core register port, so software never polls the UART for transmission.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, minimum 2.
- BAUD_DIV, 87, divisor written to BAUD after reset.
- TIMEOUT_CYC, 2048, max cycles in WAIT_DONE (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_valid_i  in  1  producer byte valid
- s_data_i  in  8  producer byte
- s_ready_o  out  1  FIFO can accept a byte
- baud_we_i  in  1  request baud reprogram
- baud_i  in  16  new divisor
- uart_we_o  out  1  write strobe to uart_core
- uart_ren_o  out  1  read strobe; tied 0
- uart_addr_o  out  8  register address
- uart_wdata_o  out  32  write data
- uart_intr_tx_i  in  1  uart_core TX-complete, level
- busy_o  out  1  state not IDLE, or FIFO not empty
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- done_o  out  1  one-cycle pulse per byte completed
- err_o  out  1  sticky timeout flag (optional feature)
- err_clr_i  in  1  clears err_o (optional feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is clk_i, reset is rst_i.
- Register map (byte addresses): BAUD 0x00, TX_DATA 0x04, RX_DATA 0x08, RX_EN 0x0C, TX_EN 0x10, STATUS 0x14. This block writes only 0x00, 0x04 and 0x10.
- Reset values:
  - uart_we_o=0, uart_addr_o=0, uart_wdata_o=0.
  - done_o=0, err_o=0, level_o=0, s_ready_o=0 during reset.
  - FIFO emptied; baud_pending=0.
  - State = CFG_BAUD, shadow divisor = BAUD_DIV.
- Bus write rule: each write is exactly one cycle with uart_we_o=1 and addr/wdata valid in that cycle. Addr and wdata hold their last values while uart_we_o=0.
- FIFO:
  - s_ready_o = !full.
  - Push on s_valid_i & s_ready_o.
  - Pop happens only in LOAD.
  - When full, no push even if a pop occurs in the same cycle.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo DEPTH; order is preserved.
- Baud request:
  - baud_we_i with baud_i!=0 latches baud_i into the shadow register and sets baud_pending. A later request overwrites the earlier one.
  - baud_i==0 is ignored.
- States:
  - CFG_BAUD: write addr 0x00, wdata = shadow zero-extended; clear baud_pending; -> IDLE.
  - IDLE: if baud_pending -> CFG_BAUD (priority); else if FIFO not empty -> LOAD; else stay.
  - LOAD: write addr 0x04, wdata = {24'b0, head byte}; pop -> START.
  - START: write addr 0x10, wdata 1 -> WAIT_DONE.
  - WAIT_DONE: no write; uart_intr_tx_i=1 -> CLR.
  - CLR: write addr 0x10, wdata 0; done_o=1 this cycle -> GAP.
  - GAP: wait for uart_intr_tx_i=0 -> IDLE.
- Latency:
  - Byte pushed at cycle N into an empty FIFO while IDLE: LOAD write at N+2, START at N+3.
  - intr_tx high at cycle M: CLR write and done_o at M+1.
- A baud request arriving mid-byte is served only after GAP, before the next byte. The byte in flight is never re-timed.
- Reset asserted in any state: all bus activity stops that cycle; FIFO contents are lost. After release, the first action is CFG_BAUD using BAUD_DIV, not the previously latched divisor.

Optional Feature:
- Macro: UART_TX_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - If it reaches TIMEOUT_CYC without intr_tx, err_o is set (sticky) and the FSM goes to CLR with done_o suppressed.
  - err_clr_i clears err_o; a new timeout in the same cycle wins.
- Undefined: no counter; err_o tied 0; err_clr_i ignored; WAIT_DONE waits indefinitely.

Test Plan:
- Reset release -> the next cycle writes addr 0x00, wdata 87; then IDLE, busy_o=0.
- Push 0xA5; intr_tx pulse 870 cycles after START -> writes (0x04, 0xA5), (0x10, 1), then (0x10, 0); done_o pulses once.
- Push 9 bytes back-to-back with no intr_tx -> level_o saturates at 8 and s_ready_o=0 until the first pop. Then release intr_tx per byte; all 9 bytes are written to 0x04 in push order.
- baud_we_i with baud_i=434 during WAIT_DONE for byte 1, byte 2 queued -> sequence is CLR, GAP, then write (0x00, 434), then LOAD of byte 2.
- With the macro, intr_tx held 0 -> err_o=1 exactly 2048 cycles after entering WAIT_DONE; (0x10, 0) is written; no done_o. err_clr_i clears err_o.
- rst_i pulsed during WAIT_DONE with 3 bytes queued -> level_o=0, uart_we_o=0 during reset; first post-reset write is (0x00, 87).
